fp_sum_normalizer: RTL and testbench

- Post-adder stage of the floating-point adder datapath; receiving end of the 16-bit add/sub core's 17-bit result {carry, sum}.
- Takes the raw mantissa sum plus the pre-add exponent and sign, normalizes iteratively (right shift on carry-out, one left shift per cycle on leading zeros), adjusts the exponent, and flags zero, overflow and underflow.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/fp_sum_normalizer_if.sv | 29 ++
 rtl/fp_sum_normalizer.sv | 138 +++++++++++++
 tb/tb_fp_sum_normalizer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_sum_normalizer_if.sv
// rtl/fp_sum_normalizer_if.sv - operand/result handshake bundle for fp_sum_normalizer
interface fp_sum_normalizer_if #(
  parameter int MW = 16,
  parameter int EW = 8
) ();
  logic          in_valid;
  logic          in_ready;
  logic [MW:0]   in_sum;
  logic [EW-1:0] in_exp;
  logic          in_sign;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_sign;
  logic          out_zero;
  logic          out_ovf;
  logic          out_unf;

  modport master (
    output in_valid, in_sum, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_sum, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_sum_normalizer.sv
// rtl/fp_sum_normalizer.sv - iterative post-add normalizer; NORM_ROUND_EN adds RNE on carry-out
// One left shift per NORM cycle; exponent saturates instead of wrapping.
module fp_sum_normalizer #(
  parameter int MW = 16,
  parameter int EW = 8
) (
  input  logic                clk,
  input  logic                rst,
  fp_sum_normalizer_if.slave  bus,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [MW:0]   r_m, w_m_nxt;
  logic [EW-1:0] r_e, w_e_nxt;
  logic          r_s, w_s_nxt;
  logic [MW-1:0] r_mant, w_mant;
  logic [EW-1:0] r_exp, w_exp;
  logic          r_sign, w_sign;
  logic          r_zero, w_zero;
  logic          r_ovf, w_ovf;
  logic          r_unf, w_unf;
  logic          w_load;
  logic          w_e_sat;

  // e+1 would reach (or pass) all-ones, i.e. the result is infinity
  assign w_e_sat = &r_e[EW-1:1];

  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_e_nxt     = r_e;
    w_s_nxt     = r_s;
    w_load      = 1'b0;
    w_mant      = '0;
    w_exp       = '0;
    w_sign      = r_s;
    w_zero      = 1'b0;
    w_ovf       = 1'b0;
    w_unf       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_m_nxt     = bus.in_sum;
          w_e_nxt     = bus.in_exp;
          w_s_nxt     = bus.in_sign;
          w_state_nxt = NORM;
        end
      end
      NORM: begin
        if (r_m == '0) begin
          w_zero      = 1'b1;
          w_sign      = 1'b0;
          w_load      = 1'b1;
          w_state_nxt = DONE;
        end else if (r_m[MW]) begin
          if (w_e_sat) begin
            w_ovf       = 1'b1;
            w_exp       = '1;
            w_load      = 1'b1;
            w_state_nxt = DONE;
          end
`ifdef NORM_ROUND_EN
          // Round up in place; the next cycle re-enters case 2 or 3 with e already bumped
          else if (r_m[1] && r_m[0]) begin
            w_m_nxt = {1'b0, r_m[MW:1]} + (MW+1)'(1);
            w_e_nxt = r_e + EW'(1);
          end
`endif
          else begin
            w_mant      = r_m[MW:1];
            w_exp       = r_e + EW'(1);
            w_load      = 1'b1;
            w_state_nxt = DONE;
          end
        end else if (r_m[MW-1]) begin
          w_mant      = r_m[MW-1:0];
          w_exp       = r_e;
          w_load      = 1'b1;
          w_state_nxt = DONE;
        end else if (r_e == '0) begin
          w_unf       = 1'b1;
          w_mant      = r_m[MW-1:0];
          w_load      = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_m_nxt = {r_m[MW-1:0], 1'b0};
          w_e_nxt = r_e - EW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_e     <= '0;
      r_s     <= 1'b0;
      r_mant  <= '0;
      r_exp   <= '0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_m     <= w_m_nxt;
      r_e     <= w_e_nxt;
      r_s     <= w_s_nxt;
      if (w_load) begin
        r_mant <= w_mant;
        r_exp  <= w_exp;
        r_sign <= w_sign;
        r_zero <= w_zero;
        r_ovf  <= w_ovf;
        r_unf  <= w_unf;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_mant  = r_mant;
  assign bus.out_exp   = r_exp;
  assign bus.out_sign  = r_sign;
  assign bus.out_zero  = r_zero;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_unf   = r_unf;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_fp_sum_normalizer.sv
// tb/tb_fp_sum_normalizer.sv - scoreboard bench for fp_sum_normalizer (honours NORM_ROUND_EN)
module tb_fp_sum_normalizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    logic [15:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        zero;
    logic        ovf;
    logic        unf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fp_sum_normalizer_if #(.MW(16), .EW(8)) bus_if ();

  fp_sum_normalizer #(.MW(16), .EW(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [16:0] sum, input logic [7:0] e, input logic sg);
    exp_t r;
    int p, k, e1;
    logic [16:0] mr;
    r.mant = '0; r.exp = '0; r.zero = 0; r.ovf = 0; r.unf = 0; r.lat = 2;
    if (sum == '0) begin
      r.zero = 1'b1;
    end else if (sum[16]) begin
      e1 = int'(e) + 1;
      r.mant = sum[16:1];
`ifdef NORM_ROUND_EN
      if (sum[1] && sum[0] && e1 < 255) begin
        r.lat = 3;
        if (r.mant == 16'hFFFF) begin
          r.mant = 16'h8000;
          e1 = int'(e) + 2;
        end else begin
          r.mant = r.mant + 16'd1;
        end
      end
`endif
      if (e1 >= 255) begin
        r.ovf = 1'b1; r.mant = '0; r.exp = 8'hFF;
      end else begin
        r.exp = e1[7:0];
      end
    end else begin
      p = 15;
      while (!sum[p]) p--;
      k = 15 - p;
      if (int'(e) >= k) begin
        mr = sum << k;
        r.mant = mr[15:0]; r.exp = e - 8'(k); r.lat = 2 + k;
      end else begin
        mr = sum << e;
        r.mant = mr[15:0]; r.exp = '0; r.unf = 1'b1; r.lat = 2 + int'(e);
      end
    end
    r.sign = r.zero ? 1'b0 : sg;
    return r;
  endfunction

  // Edges counted from the accept edge (which counts as 1) until out_valid is seen
  task automatic wait_valid(output int n, output bit ok);
    n = 1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.out_valid) begin ok = 1; return; end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic compare_out(input string tag, input int n);
    exp_t e;
    e = sb.pop_front();
    check({tag, ".mant"}, bus_if.out_mant, e.mant);
    check({tag, ".exp"},  bus_if.out_exp,  e.exp);
    check({tag, ".sign"}, bus_if.out_sign, e.sign);
    check({tag, ".zero"}, bus_if.out_zero, e.zero);
    check({tag, ".ovf"},  bus_if.out_ovf,  e.ovf);
    check({tag, ".unf"},  bus_if.out_unf,  e.unf);
    check({tag, ".lat"},  n,               e.lat);
  endtask

  task automatic accept(input logic [16:0] sum, input logic [7:0] e, input logic sg);
    bus_if.in_valid = 1'b1;
    bus_if.in_sum   = sum;
    bus_if.in_exp   = e;
    bus_if.in_sign  = sg;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [16:0] sum, input logic [7:0] e, input logic sg);
    int n;
    bit ok;
    sb.push_back(model(sum, e, sg));
    check({tag, ".in_ready"}, bus_if.in_ready, 1);
    accept(sum, e, sg);
    check({tag, ".busy"}, busy, 1);
    wait_valid(n, ok);
    if (!ok) begin
      check({tag, ".timeout"}, 0, 1);
      void'(sb.pop_front());
    end else begin
      compare_out(tag, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".in_ready"},  bus_if.in_ready,  1);
    check({tag, ".out_valid"}, bus_if.out_valid, 0);
    check({tag, ".busy"},      busy,             0);
    check({tag, ".outs"}, {bus_if.out_mant, bus_if.out_exp, bus_if.out_sign,
                           bus_if.out_zero, bus_if.out_ovf, bus_if.out_unf}, 0);
  endtask

  initial begin
    int n;
    bit ok;
    logic [16:0] rs;
    logic [15:0] held_mant;
    bus_if.in_valid  = 1'b0;
    bus_if.in_sum    = '0;
    bus_if.in_exp    = '0;
    bus_if.in_sign   = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    run_op("norm",    17'h0_8000, 8'd10,  1'b0);
    run_op("carry",   17'h1_0003, 8'd10,  1'b1);
    run_op("shift15", 17'h0_0001, 8'd20,  1'b0);
    run_op("unf",     17'h0_0010, 8'd3,   1'b1);
    run_op("ovf",     17'h1_0000, 8'hFE,  1'b0);
    run_op("zero",    17'h0_0000, 8'd77,  1'b1);
    run_op("rcarry",  17'h1_FFFF, 8'd5,   1'b0);
    run_op("ovf_ff",  17'h1_0001, 8'hFF,  1'b1);
    run_op("exact",   17'h0_0100, 8'd7,   1'b0);
    run_op("rnd_ovf", 17'h1_FFFF, 8'hFD,  1'b1);
    for (int i = 0; i < 8; i++) begin
      rs = 17'($urandom) >> $urandom_range(0, 16);
      run_op($sformatf("rand%0d", i), rs, 8'($urandom), 1'($urandom));
    end

    // Backpressure: result must hold while a competing input is offered and dropped
    sb.push_back(model(17'h0_8000, 8'd10, 1'b1));
    bus_if.out_ready = 1'b0;
    accept(17'h0_8000, 8'd10, 1'b1);
    wait_valid(n, ok);
    if (!ok) begin
      check("bp.timeout", 0, 1);
      void'(sb.pop_front());
    end else begin
      compare_out("bp", n);
    end
    held_mant = bus_if.out_mant;
    bus_if.in_valid = 1'b1;
    bus_if.in_sum   = 17'h0_0001;
    bus_if.in_exp   = 8'd40;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.hold_valid", bus_if.out_valid, 1);
      check("bp.hold_mant",  bus_if.out_mant,  16'h8000);
      check("bp.hold_exp",   bus_if.out_exp,   8'd10);
      check("bp.in_ready",   bus_if.in_ready,  0);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.release_valid", bus_if.out_valid, 0);
    check("bp.release_ready", bus_if.in_ready,  1);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp.dropped_busy", busy, 0);
    end
    check("bp.mant_kept", bus_if.out_mant, held_mant);

    // Reset partway through the 15-shift case
    accept(17'h0_0001, 8'd20, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("midrst");
    rst = 1'b0;
    run_op("after_rst", 17'h0_8000, 8'd10, 1'b0);

    check("sb.empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
